// File: rtl/control_sequencer_if.sv
// Instruction handshake between the issuing CPU front end and control_sequencer.
// The master presents run/instr; the sequencer answers with busy/done.
interface control_sequencer_if #(
  parameter int DATA_W = 16
);
  logic              run;
  logic [DATA_W-1:0] instr;
  logic              busy;
  logic              done;

  modport master (output run, instr, input busy, done);
  modport slave  (input run, instr, output busy, done);
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle control unit for the bus CPU: owns the instruction register and the
// T1..T3 step FSM, and drives one-hot register enables plus datapath strobes.
module control_sequencer #(
  parameter  int DATA_W   = 16,
  parameter  int NUM_REGS = 8,
  localparam int RS_W     = $clog2(NUM_REGS)
) (
  input  logic                clock,
  input  logic                reset,
  control_sequencer_if.slave  bus,
  input  logic                zero,
  output logic [NUM_REGS-1:0] rin,
  output logic [NUM_REGS-1:0] rout,
  output logic                gin,
  output logic                gout,
  output logic                a_in,
  output logic                addsub,
  output logic                xorctrl,
  output logic                pcin,
  output logic                pcout,
  output logic                ctrl_out,
  output logic [DATA_W-1:0]   imm_out
);

  localparam int IMM_W = DATA_W - 3 - RS_W;

  typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

  typedef enum logic [2:0] {
    OP_LD   = 3'b000,
    OP_MV   = 3'b001,
    OP_LDPC = 3'b010,
    OP_BR   = 3'b011,
    OP_ADD  = 3'b100,
    OP_SUB  = 3'b101,
    OP_XOR  = 3'b110,
    OP_BRZ  = 3'b111
  } op_t;

  typedef struct packed {
    logic [NUM_REGS-1:0] rin;
    logic [NUM_REGS-1:0] rout;
    logic [NUM_REGS-1:0] brz_sel;
    logic                gin;
    logic                gout;
    logic                a_in;
    logic                addsub;
    logic                xorctrl;
    logic                pcin;
    logic                pcout;
    logic                ctrl_out;
    logic                busy;
    logic                done;
  } ctrl_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] ir, ir_n;
  ctrl_t             ctl;
  op_t               ir_op;

  assign ir_op = op_t'(ir[DATA_W-1 -: 3]);

  function automatic ctrl_t decode(input state_t s, input logic [DATA_W-1:0] w);
    ctrl_t               c;
    op_t                 op;
    logic [NUM_REGS-1:0] x_sel;
    logic [NUM_REGS-1:0] y_sel;
    c     = '0;
    op    = op_t'(w[DATA_W-1 -: 3]);
    x_sel = NUM_REGS'(1) << w[DATA_W-4 -: RS_W];
    y_sel = NUM_REGS'(1) << w[DATA_W-4-RS_W -: RS_W];
    c.busy = (s != IDLE);
    case (s)
      T1: begin
        case (op)
          OP_LD:   begin c.ctrl_out = 1'b1; c.rin = x_sel; c.done = 1'b1; end
          OP_MV:   begin c.rout = y_sel; c.rin = x_sel; c.done = 1'b1; end
          OP_LDPC: begin c.pcout = 1'b1; c.rin = x_sel; c.done = 1'b1; end
          OP_BR:   begin c.rout = x_sel; c.pcin = 1'b1; c.done = 1'b1; end
          OP_BRZ:  begin c.brz_sel = x_sel; c.done = 1'b1; end
          default: begin c.rout = x_sel; c.a_in = 1'b1; end
        endcase
      end
      T2: begin
        c.rout    = y_sel;
        c.gin     = 1'b1;
        c.addsub  = (op == OP_SUB);
        c.xorctrl = (op == OP_XOR);
      end
      T3: begin
        c.gout = 1'b1;
        c.rin  = x_sel;
        c.done = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    state_n = state;
    ir_n    = ir;
    case (state)
      IDLE: if (bus.run) begin
        ir_n    = bus.instr;
        state_n = T1;
      end
      T1:      state_n = (ir_op inside {OP_ADD, OP_SUB, OP_XOR}) ? T2 : IDLE;
      T2:      state_n = T3;
      default: state_n = IDLE;
    endcase
  end

  // Strobes are decoded from the next state/IR so they appear registered in the step itself.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ir    <= '0;
      ctl   <= '0;
    end else begin
      state <= state_n;
      ir    <= ir_n;
      ctl   <= decode(state_n, ir_n);
    end
  end

  // BRZ evaluates the live zero flag during its T1 step; brz_sel holds the candidate rx select.
  assign rin      = ctl.rin;
  assign rout     = ctl.rout | (zero ? ctl.brz_sel : '0);
  assign pcin     = ctl.pcin | (zero & (|ctl.brz_sel));
  assign gin      = ctl.gin;
  assign gout     = ctl.gout;
  assign a_in     = ctl.a_in;
  assign addsub   = ctl.addsub;
  assign xorctrl  = ctl.xorctrl;
  assign pcout    = ctl.pcout;
  assign ctrl_out = ctl.ctrl_out;
  assign bus.busy = ctl.busy;
  assign bus.done = ctl.done;
  assign imm_out  = {{(DATA_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};

endmodule
